writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter BIT_DEPTH, default 32, SHALL set the data-path width in bits.
REQ-002 Parameter LOG_PORT_DEPTH, default 5, SHALL set the register address width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port MemValid, input, 1 bit: the MEM-stage slot holds a real instruction.
REQ-006 Port RegWriteM, input, 1 bit: the instruction writes a register.
REQ-007 Port MemToRegM, input, 1 bit: when 1, select load data; when 0, select the ALU result.
REQ-008 Port ALUResultM, input, BIT_DEPTH: the ALU result from MEM.
REQ-009 Port ReadDataM, input, BIT_DEPTH: the data-memory load value.
REQ-010 Port WriteRegM, input, LOG_PORT_DEPTH: the destination register.
REQ-011 Port Stall, input, 1 bit: hold the MEM/WB register.
REQ-012 Port Flush, input, 1 bit: invalidate the MEM/WB register.
REQ-013 Port Rs, input, LOG_PORT_DEPTH: the decode-stage read address 1.
REQ-014 Port Rt, input, LOG_PORT_DEPTH: the decode-stage read address 2.
REQ-015 Port RD1In, input, BIT_DEPTH: raw register-file read data 1.
REQ-016 Port RD2In, input, BIT_DEPTH: raw register-file read data 2.
REQ-017 Port RegWriteAddr, output, LOG_PORT_DEPTH: the register-file write address.
REQ-018 Port RegWriteData, output, BIT_DEPTH: the register-file write data.
REQ-019 Port RegWriteEn, output, 1 bit: the register-file write enable.
REQ-020 Port RD1Byp, output, BIT_DEPTH: bypassed read data 1 to decode.
REQ-021 Port RD2Byp, output, BIT_DEPTH: bypassed read data 2 to decode.
REQ-022 Port WbValid, output, 1 bit: the MEM/WB register holds a valid instruction.
REQ-023 Port RetireCount, output, 32 bits: the count of retired instructions.

Function
REQ-024 The MEM/WB register SHALL consist of valid, RegWriteW, MemToRegW, ALUResultW, ReadDataW, WriteRegW, and a Written flag.
REQ-025 Capture rule: with Flush=0 and Stall=0, the register SHALL load all MEM inputs and set valid=MemValid and Written=0 on the rising edge; latency is 1 cycle.
REQ-026 With Flush=1, valid SHALL be 0 and Written SHALL be 0 on the next edge; Flush SHALL have priority over Stall.
REQ-027 With Stall=1 and Flush=0, all fields SHALL hold, except Written, which SHALL be set to 1 if RegWriteEn was 1 in that cycle.
REQ-028 RegWriteData SHALL equal MemToRegW ? ReadDataW : ALUResultW, combinationally.
REQ-029 RegWriteAddr SHALL equal WriteRegW.
REQ-030 RegWriteEn SHALL equal valid & RegWriteW & (WriteRegW != 0) & ~Written, so an entry held under Stall writes exactly once.
REQ-031 WbValid SHALL equal valid.
REQ-032 Bypass, write-before-read: RD1Byp SHALL equal RegWriteData when RegWriteEn=1 and RegWriteAddr==Rs, and RD1In otherwise.
REQ-033 RD2Byp SHALL apply the same rule as REQ-032 using Rt and RD2In.
REQ-034 Rs or Rt equal to 0 SHALL never be bypassed, since RegWriteEn is 0 for register 0.
REQ-035 RetireCount SHALL increment by 1 on each edge where valid=1 and Written=0 and the entry leaves or is first held, i.e. once per valid instruction, regardless of RegWriteW.
REQ-036 RetireCount SHALL wrap from 0xFFFFFFFF to 0x00000000 without flagging.
REQ-037 Simultaneous capture and flush SHALL resolve as flush; the incoming instruction SHALL be discarded and not counted.

Reset
REQ-038 While rst=1, valid, Written, all MEM/WB fields and RetireCount SHALL be 0 immediately, without waiting for clk.
REQ-039 Consequently, during reset RegWriteEn=0, RegWriteAddr=0, RegWriteData=0, WbValid=0, and RD1Byp/RD2Byp SHALL pass RD1In/RD2In through.
REQ-040 Reset asserted mid-stall SHALL discard the held entry; it SHALL produce no write after rst deasserts.

Verification
REQ-041 ALU write: MemValid=1, RegWriteM=1, MemToRegM=0, ALUResultM=0x0000002A, WriteRegM=8 -> next cycle RegWriteEn=1, RegWriteAddr=8, RegWriteData=0x2A, RetireCount=1.
REQ-042 Load plus bypass: MemToRegM=1, ReadDataM=0xDEADBEEF, WriteRegM=9, then Rs=9, RD1In=0 -> RD1Byp=0xDEADBEEF, RD2Byp=RD2In for Rt=10.
REQ-043 $0 suppression: WriteRegM=0, RegWriteM=1 -> RegWriteEn=0, Rs=0 gives RD1Byp=RD1In, RetireCount still increments.
REQ-044 Stall 3 cycles on a write to register 5 -> RegWriteEn=1 for exactly one cycle, RetireCount +1 only, outputs held.
REQ-045 Flush and Stall asserted together with a valid MEM input -> WbValid=0 and RetireCount unchanged next cycle; rst pulsed mid-stall -> all outputs 0 asynchronously.
REQ-046 RetireCount preloaded near wrap by 0xFFFFFFFF retirements (or forced) -> one more retirement yields 0x00000000.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register with write-once-under-stall register-file
// write port, write-before-read decode bypass and a retired-instruction counter.
module writeback_stage #(
  parameter int BIT_DEPTH      = 32,
  parameter int LOG_PORT_DEPTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemValid,
  input  logic                      RegWriteM,
  input  logic                      MemToRegM,
  input  logic [BIT_DEPTH-1:0]      ALUResultM,
  input  logic [BIT_DEPTH-1:0]      ReadDataM,
  input  logic [LOG_PORT_DEPTH-1:0] WriteRegM,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic [LOG_PORT_DEPTH-1:0] Rs,
  input  logic [LOG_PORT_DEPTH-1:0] Rt,
  input  logic [BIT_DEPTH-1:0]      RD1In,
  input  logic [BIT_DEPTH-1:0]      RD2In,
  output logic [LOG_PORT_DEPTH-1:0] RegWriteAddr,
  output logic [BIT_DEPTH-1:0]      RegWriteData,
  output logic                      RegWriteEn,
  output logic [BIT_DEPTH-1:0]      RD1Byp,
  output logic [BIT_DEPTH-1:0]      RD2Byp,
  output logic                      WbValid,
  output logic [31:0]               RetireCount
);
  logic                      valid_q, valid_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_to_reg_q, mem_to_reg_d;
  logic [BIT_DEPTH-1:0]      alu_q, alu_d;
  logic [BIT_DEPTH-1:0]      rdata_q, rdata_d;
  logic [LOG_PORT_DEPTH-1:0] wreg_q, wreg_d;
  logic                      written_q, written_d;
  logic                      retired_q, retired_d;
  logic [31:0]               retire_cnt_q, retire_cnt_d;
  logic                      capture, renew;

  assign capture = ~Flush & ~Stall;
  assign renew   = Flush | ~Stall;

  assign RegWriteAddr = wreg_q;
  assign RegWriteData = mem_to_reg_q ? rdata_q : alu_q;
  assign RegWriteEn   = valid_q & reg_write_q & (wreg_q != '0) & ~written_q;
  assign WbValid      = valid_q;
  assign RD1Byp       = (RegWriteEn && RegWriteAddr == Rs) ? RegWriteData : RD1In;
  assign RD2Byp       = (RegWriteEn && RegWriteAddr == Rt) ? RegWriteData : RD2In;
  assign RetireCount  = retire_cnt_q;

  // retired_q marks an entry already counted while held, so non-writing
  // instructions are also counted exactly once however long they stall.
  always_comb begin
    valid_d      = Flush ? 1'b0 : Stall ? valid_q : MemValid;
    reg_write_d  = capture ? RegWriteM : reg_write_q;
    mem_to_reg_d = capture ? MemToRegM : mem_to_reg_q;
    alu_d        = capture ? ALUResultM : alu_q;
    rdata_d      = capture ? ReadDataM : rdata_q;
    wreg_d       = capture ? WriteRegM : wreg_q;
    written_d    = renew ? 1'b0 : written_q | RegWriteEn;
    retired_d    = renew ? 1'b0 : retired_q | valid_q;
    retire_cnt_d = retire_cnt_q + {31'd0, valid_q & ~retired_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_q        <= '0;
      rdata_q      <= '0;
      wreg_q       <= '0;
      written_q    <= 1'b0;
      retired_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_q        <= alu_d;
      rdata_q      <= rdata_d;
      wreg_q       <= wreg_d;
      written_q    <= written_d;
      retired_q    <= retired_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scenarios plus randomized traffic against an
// instruction-level model of the writeback stage.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemValid, RegWriteM, MemToRegM, Stall, Flush;
  logic [31:0] ALUResultM, ReadDataM, RD1In, RD2In;
  logic [4:0]  WriteRegM, Rs, Rt;
  logic [4:0]  RegWriteAddr;
  logic [31:0] RegWriteData, RD1Byp, RD2Byp, RetireCount;
  logic        RegWriteEn, WbValid;
  int          tests = 0;
  int          fails = 0;

  writeback_stage dut (
    .clk(clk), .rst(rst), .MemValid(MemValid), .RegWriteM(RegWriteM),
    .MemToRegM(MemToRegM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .WriteRegM(WriteRegM), .Stall(Stall), .Flush(Flush), .Rs(Rs), .Rt(Rt),
    .RD1In(RD1In), .RD2In(RD2In), .RegWriteAddr(RegWriteAddr),
    .RegWriteData(RegWriteData), .RegWriteEn(RegWriteEn), .RD1Byp(RD1Byp),
    .RD2Byp(RD2Byp), .WbValid(WbValid), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  // Model: the instruction sitting in WB, whether it already wrote, whether it was counted.
  bit          m_valid, m_rw, m_m2r, m_wrote, m_counted;
  logic [31:0] m_alu, m_rd;
  logic [4:0]  m_wr;
  logic [31:0] m_cnt;

  function automatic bit m_en();
    return m_valid && m_rw && m_wr != 5'd0 && !m_wrote;
  endfunction
  function automatic logic [31:0] m_data();
    return m_m2r ? m_rd : m_alu;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_wrote = 0; m_counted = 0;
    m_alu = 0; m_rd = 0; m_wr = 0; m_cnt = 0;
  endtask

  task automatic tick();
    bit en;
    en = m_en();
    if (m_valid && !m_counted) m_cnt = m_cnt + 1;
    if (Flush) begin
      m_valid = 0; m_wrote = 0; m_counted = 0;
    end else if (Stall) begin
      if (en) m_wrote = 1;
      if (m_valid) m_counted = 1;
    end else begin
      m_valid = MemValid; m_rw = RegWriteM; m_m2r = MemToRegM;
      m_alu = ALUResultM; m_rd = ReadDataM; m_wr = WriteRegM;
      m_wrote = 0; m_counted = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit mv, bit rw, bit m2r, logic [31:0] alu, logic [31:0] rd, logic [4:0] wr);
    MemValid = mv; RegWriteM = rw; MemToRegM = m2r;
    ALUResultM = alu; ReadDataM = rd; WriteRegM = wr;
    Stall = 0; Flush = 0;
  endtask

  task automatic do_reset();
    rst = 1; model_clear();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; model_clear();
    drive(1, 1, 0, 32'h11, 32'h22, 5'd3);
    Rs = 5'd3; Rt = 5'd3; RD1In = $urandom; RD2In = $urandom;
    #1;
    tests++; if (RegWriteEn !== 1'b0) begin fails++; $display("FAIL reset_en got=%b exp=0", RegWriteEn); end
    tests++; if (RegWriteAddr !== 5'd0 || RegWriteData !== 32'd0) begin fails++; $display("FAIL reset_wdata got=%0d/%h exp=0/0", RegWriteAddr, RegWriteData); end
    tests++; if (WbValid !== 1'b0 || RetireCount !== 32'd0) begin fails++; $display("FAIL reset_state got=%b/%h exp=0/0", WbValid, RetireCount); end
    tests++; if (RD1Byp !== RD1In || RD2Byp !== RD2In) begin fails++; $display("FAIL reset_byp got=%h/%h exp=%h/%h", RD1Byp, RD2Byp, RD1In, RD2In); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_alu_write();
    do_reset();
    drive(1, 1, 0, 32'h2A, 32'hFFFF_0000, 5'd8);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (RegWriteEn !== 1'b1 || RegWriteAddr !== 5'd8 || RegWriteData !== 32'h2A) begin fails++; $display("FAIL alu_write got=%b/%0d/%h exp=1/8/2a", RegWriteEn, RegWriteAddr, RegWriteData); end
    tick();
    tests++; if (RetireCount !== 32'd1) begin fails++; $display("FAIL alu_retire got=%0d exp=1", RetireCount); end
  endtask

  task automatic test_load_bypass();
    do_reset();
    drive(1, 1, 1, 32'h1234, 32'hDEAD_BEEF, 5'd9);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    Rs = 5'd9; Rt = 5'd10; RD1In = 32'd0; RD2In = $urandom;
    #1;
    tests++; if (RD1Byp !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_byp1 got=%h exp=deadbeef", RD1Byp); end
    tests++; if (RD2Byp !== RD2In) begin fails++; $display("FAIL load_byp2 got=%h exp=%h", RD2Byp, RD2In); end
    Rt = 5'd9; #1;
    tests++; if (RD2Byp !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_byp2_hit got=%h exp=deadbeef", RD2Byp); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1, 1, 0, 32'h55, 32'h66, 5'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    Rs = 5'd0; Rt = 5'd0; RD1In = $urandom; RD2In = $urandom;
    #1;
    tests++; if (RegWriteEn !== 1'b0) begin fails++; $display("FAIL zero_en got=%b exp=0", RegWriteEn); end
    tests++; if (RD1Byp !== RD1In || RD2Byp !== RD2In) begin fails++; $display("FAIL zero_byp got=%h/%h exp=%h/%h", RD1Byp, RD2Byp, RD1In, RD2In); end
    tick();
    tests++; if (RetireCount !== 32'd1) begin fails++; $display("FAIL zero_retire got=%0d exp=1", RetireCount); end
  endtask

  task automatic test_stall();
    int ens = 0;
    do_reset();
    drive(1, 1, 0, 32'h77, 32'h88, 5'd5);
    tick();
    drive(1, 1, 1, 32'h99, 32'hAA, 5'd6);
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      ens += int'(RegWriteEn);
      tests++; if (RegWriteAddr !== 5'd5 || RegWriteData !== 32'h77 || WbValid !== 1'b1) begin fails++; $display("FAIL stall_hold%0d got=%0d/%h/%b exp=5/77/1", i, RegWriteAddr, RegWriteData, WbValid); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tests++; if (ens != 1) begin fails++; $display("FAIL stall_once got=%0d exp=1", ens); end
    tests++; if (RetireCount !== 32'd1) begin fails++; $display("FAIL stall_retire got=%0d exp=1", RetireCount); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    drive(1, 1, 0, 32'h33, 32'h44, 5'd7);
    Stall = 1; Flush = 1;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (WbValid !== 1'b0 || RegWriteEn !== 1'b0) begin fails++; $display("FAIL flush_valid got=%b/%b exp=0/0", WbValid, RegWriteEn); end
    tick();
    tests++; if (RetireCount !== 32'd0) begin fails++; $display("FAIL flush_retire got=%0d exp=0", RetireCount); end
  endtask

  task automatic test_reset_mid_stall();
    int ens = 0;
    do_reset();
    drive(1, 1, 0, 32'hCAFE, 32'h0, 5'd6);
    tick();
    Stall = 1; Rs = 5'd6; Rt = 5'd6; RD1In = $urandom; RD2In = $urandom;
    #1;
    tests++; if (RegWriteEn !== 1'b1) begin fails++; $display("FAIL rststall_pre got=%b exp=1", RegWriteEn); end
    #1 rst = 1; model_clear();
    #1;
    tests++; if (RegWriteEn !== 1'b0 || WbValid !== 1'b0 || RegWriteAddr !== 5'd0 || RegWriteData !== 32'd0 || RetireCount !== 32'd0) begin fails++; $display("FAIL rststall_async got=%b/%b/%0d/%h/%0d exp=0/0/0/0/0", RegWriteEn, WbValid, RegWriteAddr, RegWriteData, RetireCount); end
    tests++; if (RD1Byp !== RD1In || RD2Byp !== RD2In) begin fails++; $display("FAIL rststall_byp got=%h/%h exp=%h/%h", RD1Byp, RD2Byp, RD1In, RD2In); end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin #1 ens += int'(RegWriteEn); tick(); end
    Stall = 0; MemValid = 0;
    #1 ens += int'(RegWriteEn);
    tests++; if (ens != 0) begin fails++; $display("FAIL rststall_nowrite got=%0d exp=0", ens); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 0, 0, 32'h1, 32'h2, 5'd4);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tests++; if (RetireCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_pre got=%h exp=ffffffff", RetireCount); end
    tick();
    tests++; if (RetireCount !== 32'h0) begin fails++; $display("FAIL wrap got=%h exp=0", RetireCount); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, $urandom, 5'($urandom_range(0, 3)));
      Stall = $urandom_range(0, 2) == 0;
      Flush = $urandom_range(0, 5) == 0;
      Rs = 5'($urandom_range(0, 3)); Rt = 5'($urandom_range(0, 3));
      RD1In = $urandom; RD2In = $urandom;
      #1;
      tests++;
      if (RegWriteEn !== m_en() || RegWriteAddr !== m_wr || RegWriteData !== m_data() ||
          WbValid !== m_valid || RetireCount !== m_cnt ||
          RD1Byp !== ((m_en() && m_wr == Rs) ? m_data() : RD1In) ||
          RD2Byp !== ((m_en() && m_wr == Rt) ? m_data() : RD2In)) begin
        fails++;
        if (bad++ < 10)
          $display("FAIL random cyc=%0d got en=%b a=%0d d=%h v=%b c=%0d b1=%h b2=%h exp en=%b a=%0d d=%h v=%b c=%0d",
                   i, RegWriteEn, RegWriteAddr, RegWriteData, WbValid, RetireCount, RD1Byp, RD2Byp,
                   m_en(), m_wr, m_data(), m_valid, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    Rs = 0; Rt = 0; RD1In = 0; RD2In = 0;
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_zero_reg();
    test_stall();
    test_flush_stall();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
